// File: rtl/jaxa_stat_pkg.sv
// jaxa_stat_pkg: shared FSM state type and PIO constants for the
// SpaceWire statistics poller.
package jaxa_stat_pkg;

    // Poller sequencing states, one pass of SETTLE..CAPTURE per counter index.
    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        READ,
        LAT,
        CAPTURE
    } stat_state_t;

    // The PIO input slave exposes its data register at address 0.
    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    // Width of the PIO data path.
    localparam int PIO_DATA_W = 32;

endpackage

// File: rtl/jaxa_stat_interval_timer.sv
// jaxa_stat_interval_timer: idle-interval counter for periodic sweeps.
// Reloads with period on each completed sweep and on a fresh auto_en,
// counts IDLE cycles down to zero, and raises trigger once it is there.
module jaxa_stat_interval_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                auto_en,
    input  logic                idle,
    input  logic                reload,
    input  logic [PERIOD_W-1:0] period,
    output logic                trigger
);

    logic [PERIOD_W-1:0] count;
    logic                auto_en_q;
    logic                auto_rise;

    assign auto_rise = auto_en && !auto_en_q;

    // A fresh enable loads the interval first, so it never fires on the rising cycle.
    assign trigger = auto_en && idle && !auto_rise && (count == '0);

    // Remember the previous auto_en so a rising edge can be recognised.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_en_q <= 1'b0;
        end else begin
            auto_en_q <= auto_en;
        end
    end

    // Reload on sweep completion or fresh enable, else count idle cycles down, holding at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (reload || (auto_rise && idle)) begin
            count <= period;
        end else if (auto_en && idle && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/jaxa_stat_poller.sv
// jaxa_stat_poller: Avalon-MM read initiator that sweeps the SpaceWire
// statistics counters through a 32-bit PIO input slave. For each index it
// drives the counter-mux select, waits for the mux to settle, reads PIO
// address 0 and emits the value as an indexed snapshot.
// Optional build macro STAT_POLL_DELTA_EN: report the difference from the
// previous sweep's reading (modulo 2^32) instead of the raw counter value.
module jaxa_stat_poller
    import jaxa_stat_pkg::*;
#(
    parameter int NUM_STATS    = 8,
    parameter int SEL_W        = 4,
    parameter int SETTLE_CYC   = 2,
    parameter int READ_LATENCY = 1,
    parameter int PERIOD_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  auto_en,
    input  logic [PERIOD_W-1:0]   period,
    output logic [SEL_W-1:0]      stat_sel,
    output logic [1:0]            avm_address,
    output logic                  avm_read,
    input  logic [PIO_DATA_W-1:0] avm_readdata,
    output logic                  snap_valid,
    output logic [SEL_W-1:0]      snap_index,
    output logic [PIO_DATA_W-1:0] snap_data,
    output logic                  sweep_done,
    output logic                  busy
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [3:0]       LAT_LAST    = 4'(READ_LATENCY - 1);
    localparam logic [SEL_W-1:0] IDX_LAST    = SEL_W'(NUM_STATS - 1);

    stat_state_t           state;
    logic [SEL_W-1:0]      idx;
    logic [3:0]            cnt;
    logic                  auto_trigger;
    logic                  in_idle;
    logic                  sample_now;
    logic                  last_idx;
    logic [PIO_DATA_W-1:0] sample_value;

    assign in_idle     = (state == IDLE);
    assign sample_now  = (state == LAT) && (cnt == LAT_LAST);
    assign last_idx    = (idx == IDX_LAST);
    assign avm_address = PIO_DATA_ADDR;

    jaxa_stat_interval_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_interval_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .auto_en (auto_en),
        .idle    (in_idle),
        .reload  (sweep_done),
        .period  (period),
        .trigger (auto_trigger)
    );

`ifdef STAT_POLL_DELTA_EN
    localparam int IDX_W = (NUM_STATS > 1) ? $clog2(NUM_STATS) : 1;

    logic [PIO_DATA_W-1:0] prev_value [NUM_STATS];
    logic [PIO_DATA_W-1:0] raw_value;

    // Unsigned subtraction wraps, so a counter rollover still yields the true positive delta.
    assign sample_value = avm_readdata - prev_value[idx[IDX_W-1:0]];

    // Hold the raw reading taken at the sample point until it is committed to history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_value <= '0;
        end else if (sample_now) begin
            raw_value <= avm_readdata;
        end
    end

    // Commit the raw reading as the reference for the next sweep during CAPTURE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_STATS; i++) begin
                prev_value[i] <= '0;
            end
        end else if (state == CAPTURE) begin
            prev_value[idx[IDX_W-1:0]] <= raw_value;
        end
    end
`else
    assign sample_value = avm_readdata;
`endif

    // Sweep sequencer: select, settle, read, wait for data, capture, next index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            stat_sel   <= '0;
            avm_read   <= 1'b0;
            snap_valid <= 1'b0;
            snap_index <= '0;
            snap_data  <= '0;
            sweep_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start || auto_trigger) begin
                        state    <= SETTLE;
                        idx      <= '0;
                        cnt      <= '0;
                        stat_sel <= '0;
                        busy     <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state    <= READ;
                        cnt      <= '0;
                        avm_read <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READ: begin
                    state    <= LAT;
                    cnt      <= '0;
                    avm_read <= 1'b0;
                end
                LAT: begin
                    if (cnt == LAT_LAST) begin
                        state      <= CAPTURE;
                        cnt        <= '0;
                        snap_valid <= 1'b1;
                        snap_index <= idx;
                        snap_data  <= sample_value;
                        sweep_done <= last_idx;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    snap_valid <= 1'b0;
                    sweep_done <= 1'b0;
                    cnt        <= '0;
                    if (last_idx) begin
                        state    <= IDLE;
                        idx      <= '0;
                        stat_sel <= '0;
                        busy     <= 1'b0;
                    end else begin
                        state    <= SETTLE;
                        idx      <= idx + 1'b1;
                        stat_sel <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jaxa_stat_poller.sv
// tb_jaxa_stat_poller: directed self-checking bench for jaxa_stat_poller.
// Models a counter mux whose output lags stat_sel by one cycle and a PIO
// slave with one cycle of read latency that drives junk outside valid data.
`timescale 1ns/1ps
module tb_jaxa_stat_poller;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        start    = 1'b0;
    logic        auto_en  = 1'b0;
    logic [15:0] period   = 16'd0;
    logic [3:0]  stat_sel;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        snap_valid;
    logic [3:0]  snap_index;
    logic [31:0] snap_data;
    logic        sweep_done;
    logic        busy;

    int n_compared = 0;
    int n_mismatch = 0;

    int          busy_cycles;
    int          busy_rises;
    int          n_read;
    int          addr_bad;
    int          settle_bad;
    int          done_count;
    int          sel_age;
    int          gap_cnt;
    bit          gap_armed;
    logic [3:0]  done_idx;
    logic        busy_prev;
    logic [3:0]  sel_prev;
    logic [3:0]  snap_idx_q [$];
    logic [31:0] snap_dat_q [$];
    int          gap_q [$];

    logic [3:0]  sel_d    = 4'd0;
    logic        rd_valid = 1'b0;
    logic [31:0] rd_reg   = 32'd0;
    bit          delta_mode = 1'b0;
    logic [31:0] delta_val  = 32'd0;
    logic [31:0] mux_out;

`ifdef STAT_POLL_DELTA_EN
    logic [31:0] model_prev [8];
`endif

    jaxa_stat_poller dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .auto_en      (auto_en),
        .period       (period),
        .stat_sel     (stat_sel),
        .avm_address  (avm_address),
        .avm_read     (avm_read),
        .avm_readdata (avm_readdata),
        .snap_valid   (snap_valid),
        .snap_index   (snap_index),
        .snap_data    (snap_data),
        .sweep_done   (sweep_done),
        .busy         (busy)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Counter mux output follows stat_sel one cycle late.
    assign mux_out = (delta_mode && sel_d == 4'd0) ? delta_val
                                                   : 32'h1000_0000 + {28'd0, sel_d};

    // PIO slave: data valid one cycle after the read strobe, junk otherwise.
    always @(posedge clk) begin
        sel_d    <= stat_sel;
        rd_valid <= avm_read;
        if (avm_read) rd_reg <= mux_out;
    end
    assign avm_readdata = rd_valid ? rd_reg : 32'hDEAD_BEEF;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic clearMonitor();
        busy_cycles = 0;
        busy_rises  = 0;
        n_read      = 0;
        addr_bad    = 0;
        settle_bad  = 0;
        done_count  = 0;
        done_idx    = 4'hF;
        sel_age     = 0;
        gap_cnt     = 0;
        gap_armed   = 1'b0;
        busy_prev   = busy;
        sel_prev    = stat_sel;
        snap_idx_q.delete();
        snap_dat_q.delete();
        gap_q.delete();
    endtask

    task automatic resetModel();
`ifdef STAT_POLL_DELTA_EN
        for (int i = 0; i < 8; i++) model_prev[i] = 32'd0;
`endif
    endtask

    // Advance to the next falling edge and record what the DUT did in that cycle.
    task automatic tick();
        @(negedge clk);
        if (busy) busy_cycles++;
        if (busy && !busy_prev) begin
            busy_rises++;
            sel_age = 0;
        end else if (stat_sel != sel_prev) begin
            sel_age = 0;
        end else begin
            sel_age++;
        end
        if (avm_read) begin
            n_read++;
            if (avm_address != 2'd0) addr_bad++;
            if (sel_age != 2) settle_bad++;
        end
        if (snap_valid) begin
            snap_idx_q.push_back(snap_index);
            snap_dat_q.push_back(snap_data);
        end
        if (gap_armed && busy) begin
            gap_q.push_back(gap_cnt);
            gap_armed = 1'b0;
        end else if (gap_armed) begin
            gap_cnt++;
        end
        if (sweep_done) begin
            done_count++;
            done_idx  = snap_valid ? snap_index : 4'hF;
            gap_armed = 1'b1;
            gap_cnt   = 0;
        end
        busy_prev = busy;
        sel_prev  = stat_sel;
    endtask

    task automatic waitDone(input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = sweep_done;
        end
        checkOutput({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic waitGaps(input int budget, input string tag);
        for (int i = 0; i < budget && gap_q.size() < 2; i++) tick();
        checkOutput({tag, "_gap_count_ok"}, {31'd0, gap_q.size() >= 2}, 32'd1);
    endtask

    // One start-triggered sweep; optionally pulse start again at busy cycle 5.
    task automatic applyStimulus(input bit collide, input string tag);
        clearMonitor();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (collide) begin
            repeat (4) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        waitDone(200, tag);
        repeat (15) tick();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_stat_sel"},   {28'd0, stat_sel},   32'd0);
        checkOutput({tag, "_avm_addr"},   {30'd0, avm_address}, 32'd0);
        checkOutput({tag, "_avm_read"},   {31'd0, avm_read},   32'd0);
        checkOutput({tag, "_snap_valid"}, {31'd0, snap_valid}, 32'd0);
        checkOutput({tag, "_snap_index"}, {28'd0, snap_index}, 32'd0);
        checkOutput({tag, "_snap_data"},  snap_data,           32'd0);
        checkOutput({tag, "_sweep_done"}, {31'd0, sweep_done}, 32'd0);
        checkOutput({tag, "_busy"},       {31'd0, busy},       32'd0);
    endtask

    task automatic checkSweep(input string tag);
        logic [31:0] raw;
        logic [31:0] expv;
        checkOutput({tag, "_snap_count"},  snap_idx_q.size(), 32'd8);
        checkOutput({tag, "_busy_cycles"}, busy_cycles,       32'd40);
        checkOutput({tag, "_busy_rises"},  busy_rises,        32'd1);
        checkOutput({tag, "_reads"},       n_read,            32'd8);
        checkOutput({tag, "_addr_bad"},    addr_bad,          32'd0);
        checkOutput({tag, "_settle_bad"},  settle_bad,        32'd0);
        checkOutput({tag, "_done_count"},  done_count,        32'd1);
        checkOutput({tag, "_done_idx"},    {28'd0, done_idx}, 32'd7);
        for (int i = 0; i < snap_idx_q.size() && i < 8; i++) begin
            raw  = 32'h1000_0000 + i;
            expv = raw;
`ifdef STAT_POLL_DELTA_EN
            expv = raw - model_prev[i];
            model_prev[i] = raw;
`endif
            checkOutput($sformatf("%s_idx%0d", tag, i), {28'd0, snap_idx_q[i]}, i);
            checkOutput($sformatf("%s_data%0d", tag, i), snap_dat_q[i], expv);
        end
    endtask

    initial begin
        bit seen;
        logic [31:0] d0;
        resetModel();
        clearMonitor();

        // Reset state
        repeat (3) tick();
        checkReset("reset");
        reset_n = 1'b1;
        repeat (3) tick();
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        // Single sweep and start collision
        applyStimulus(1'b0, "single");
        checkSweep("single");
        applyStimulus(1'b1, "collide");
        checkSweep("collide");

        // Auto mode with period 10, then 0, then auto_en dropped mid-sweep
        $display("[TB] auto mode");
        clearMonitor();
        period  = 16'd10;
        auto_en = 1'b1;
        waitGaps(400, "p10");
        checkOutput("p10_gap0", gap_q.size() > 0 ? gap_q[0] : -1, 32'd11);
        checkOutput("p10_gap1", gap_q.size() > 1 ? gap_q[1] : -1, 32'd11);
        period = 16'd0;
        clearMonitor();
        waitGaps(300, "p0");
        checkOutput("p0_gap0", gap_q.size() > 0 ? gap_q[0] : -1, 32'd1);
        checkOutput("p0_gap1", gap_q.size() > 1 ? gap_q[1] : -1, 32'd1);
        repeat (10) tick();
        auto_en = 1'b0;
        clearMonitor();
        waitDone(100, "auto_off");
        repeat (60) tick();
        checkOutput("auto_off_done_count", done_count, 32'd1);
        checkOutput("auto_off_rises", busy_rises, 32'd0);
        checkOutput("auto_off_busy", {31'd0, busy}, 32'd0);

        // Reset while index 3 waits for read data
        $display("[TB] reset mid-sweep");
        clearMonitor();
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            seen = snap_valid && (snap_index == 4'd2);
        end
        checkOutput("rst_reach_idx2", {31'd0, seen}, 32'd1);
        repeat (3) tick();
        checkOutput("rst_read_idx3", {31'd0, avm_read}, 32'd1);
        checkOutput("rst_sel_idx3", {28'd0, stat_sel}, 32'd3);
        tick();
        reset_n = 1'b0;
        #1;
        checkReset("midreset");
        resetModel();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        applyStimulus(1'b0, "restart");
        checkSweep("restart");

`ifdef STAT_POLL_DELTA_EN
        // Counter 0 wraps between two sweeps
        $display("[TB] delta mode");
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        resetModel();
        delta_mode = 1'b1;
        delta_val  = 32'hFFFF_FFF0;
        applyStimulus(1'b0, "delta1");
        d0 = (snap_dat_q.size() > 0) ? snap_dat_q[0] : 32'hXXXX_XXXX;
        checkOutput("delta1_data0", d0, 32'hFFFF_FFF0);
        delta_val = 32'h0000_0010;
        applyStimulus(1'b0, "delta2");
        d0 = (snap_dat_q.size() > 0) ? snap_dat_q[0] : 32'hXXXX_XXXX;
        checkOutput("delta2_data0", d0, 32'h0000_0020);
        d0 = (snap_dat_q.size() > 1) ? snap_dat_q[1] : 32'hXXXX_XXXX;
        checkOutput("delta2_data1", d0, 32'h0000_0000);
        delta_mode = 1'b0;
`else
        d0 = snap_data;
        checkOutput("final_snap_data", d0, 32'h1000_0007);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
